config_tree_accumulator: RTL



---
 rtl/config_tree_accumulator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/config_tree_accumulator.sv
// config_tree_accumulator
// Accumulates K signed 32-bit partial sums from the tree adder into one
// dot-product result. The result is converted to OUT_W (clamped or truncated)
// and presented on a registered output together with the group's
// halved-precision mode and an overflow flag.
//
// Handshake semantics (both ports): a beat transfers on a rising clk edge
// where valid && ready. A producer holds its data stable while valid is high
// and ready is low. Ready never depends on valid on the same port. in_ready
// is derived from registered state, plus out_ready while a result is pending.
module config_tree_accumulator #(
    parameter int ACC_W    = 48,
    parameter int OUT_W    = 32,
    parameter int K_W      = 16,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [K_W-1:0]   cfg_k,
    input  logic             halvedPrecision,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_halved,
    output logic             out_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Saturation limits expressed at OUT_W.
    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [31:0]      in_sum_s;
    logic signed [ACC_W-1:0] in_ext;
    logic [K_W-1:0]          cnt;
    logic [K_W-1:0]          cnt_inc;
    logic [K_W-1:0]          k_lat;
    logic [K_W-1:0]          k_eff;
    logic                    halved_lat;

    logic accept;
    logic start;
    logic close_grp;
    logic [ACC_W-OUT_W:0]    upper;
    logic                    fits;
    logic [OUT_W-1:0]        conv_data;

    // Assigning a signed 32-bit value to a wider signed net sign-extends it.
    assign in_sum_s = in_sum;
    assign in_ext   = in_sum_s;

    assign k_eff   = (cfg_k == '0) ? K_W'(1) : cfg_k;
    assign cnt_inc = cnt + K_W'(1);

    // A beat starts a new group in IDLE, and also in OUT when the pending
    // result is being taken in the same cycle (no lost cycle between groups).
    assign accept    = in_valid && in_ready;
    assign start     = accept && (state != ACC);
    assign close_grp = (start && (k_eff == K_W'(1))) ||
                       (accept && (state == ACC) && (cnt_inc == k_lat));

    // Value the accumulator takes at the next edge.
    always_comb begin
        acc_nxt = acc;
        if (start) begin
            acc_nxt = in_ext;
        end else if (accept) begin
            acc_nxt = acc + in_ext;
        end
    end

    // Convert the closing accumulator value to OUT_W and flag lost information.
    always_comb begin
        upper     = acc_nxt[ACC_W-1:OUT_W-1];
        fits      = (&upper) || !(|upper);
        conv_data = acc_nxt[OUT_W-1:0];
        if (!fits && (SATURATE != 0)) begin
            conv_data = acc_nxt[ACC_W-1] ? MIN_NEG : MAX_POS;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (k_eff == K_W'(1)) ? OUT : ACC;
                end
            end
            ACC: begin
                if (close_grp) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (start) begin
                    state_nxt = (k_eff == K_W'(1)) ? OUT : ACC;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; in_ready is held low while reset is asserted.
    always_comb begin
        out_valid = (state == OUT);
        in_ready  = 1'b0;
        case (state)
            IDLE:    in_ready = rst_n;
            ACC:     in_ready = rst_n;
            OUT:     in_ready = rst_n && out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Accumulator, beat counter, per-group config and the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            k_lat        <= '0;
            halved_lat   <= 1'b0;
            out_data     <= '0;
            out_halved   <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            acc <= acc_nxt;
            if (start) begin
                cnt        <= K_W'(1);
                k_lat      <= k_eff;
                halved_lat <= halvedPrecision;
            end else if (accept) begin
                cnt <= cnt_inc;
            end
            if (close_grp) begin
                out_data     <= conv_data;
                out_overflow <= !fits;
                out_halved   <= start ? halvedPrecision : halved_lat;
            end
        end
    end

endmodule
